tseq_sum_reader: RTL

- Consumer end of the sequential ternary/XNOR layer's accumulator interface.
- Snapshots the layer's packed per-neuron sums when the layer reports completion, then walks them one neuron per cycle.
- Binarizes each sum against a per-neuron threshold and streams the bits out with a valid/ready handshake for the next bit-serial layer.
- Also builds a packed bit vector and the argmax index used for classification at the network output.

---
 rtl/tseq_pkg.sv | 13 +
 rtl/tseq_sum_reader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tseq_pkg.sv
// Shared definitions for the sequential ternary/XNOR layer and its sum reader.
package tseq_pkg;

    // Sum width shared with the sequential layer's accumulators.
    localparam int SUM_L = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } tseq_state_t;

endpackage : tseq_pkg

// File: rtl/tseq_sum_reader.sv
// Consumer of the sequential layer's packed sums.
// It snapshots the sums when the layer reports completion and then walks them
// one neuron per cycle. Each sum is binarized against its threshold and the
// bit is streamed out with valid/ready. The block also builds a packed bit
// vector and the argmax index of the sums.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for sums_valid; outputs from the last run are held
// STREAM | presenting neuron r_idx; advancing on each accepted transfer
// DONE   | one-cycle done pulse after the last transfer, then IDLE
module tseq_sum_reader
    import tseq_pkg::*;
#(
    parameter  int               M    = 4,
    parameter  int               SumL = SUM_L,
    parameter  logic [M*SumL-1:0] THR = '0,
    localparam int               IdxW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [M*SumL-1:0]    sums,
    input  logic                 sums_valid,
    output logic                 out_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [M-1:0]         out_bits,
    output logic [IdxW-1:0]      argmax,
    output logic                 done,
    output logic                 busy,
    output logic                 overrun
);

    tseq_state_t        r_state;
    tseq_state_t        w_state_nxt;
    logic [M*SumL-1:0]  r_snap;
    logic [IdxW-1:0]    r_idx;
    logic [SumL-1:0]    r_max;
    logic [M-1:0]       r_out_bits;
    logic [IdxW-1:0]    r_argmax;
    logic               r_overrun;

    logic [SumL-1:0]    w_cur_sum;
    logic [SumL-1:0]    w_cur_thr;
    logic               w_bit;
    logic               w_last;
    logic               w_stream;
    logic               w_xfer;
    logic               w_capture;

    assign w_cur_sum = r_snap[int'(r_idx) * SumL +: SumL];
    assign w_cur_thr = THR[int'(r_idx) * SumL +: SumL];
    assign w_bit     = (w_cur_sum >= w_cur_thr);
    assign w_last    = (int'(r_idx) == (M - 1));
    assign w_stream  = (r_state == ST_STREAM);
    assign w_xfer    = w_stream && out_ready;
    assign w_capture = (r_state == ST_IDLE) && sums_valid;

    // Bit and last flag are only meaningful while streaming; hold them low otherwise.
    assign out_bit  = w_stream & w_bit;
    assign out_last = w_stream & w_last;
    assign out_bits = r_out_bits;
    assign argmax   = r_argmax;
    assign overrun  = r_overrun;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sums_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Snapshot capture, per-transfer result update and neuron index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_idx      <= '0;
            r_max      <= '0;
            r_out_bits <= '0;
            r_argmax   <= '0;
        end else if (w_capture) begin
            r_snap     <= sums;
            r_idx      <= '0;
            r_max      <= '0;
            r_out_bits <= '0;
            r_argmax   <= '0;
        end else if (w_xfer) begin
            r_out_bits[r_idx] <= w_bit;
            // Strict compare so a tie keeps the lower index.
            if ((r_idx == '0) || (w_cur_sum > r_max)) begin
                r_max    <= w_cur_sum;
                r_argmax <= r_idx;
            end
            if (!w_last) begin
                r_idx <= r_idx + IdxW'(1);
            end
        end
    end

    // Sticky flag for a completion pulse that arrived while a run was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (sums_valid && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

endmodule : tseq_sum_reader
